// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
package pwm_pkg;

    localparam int unsigned PWM_WIDTH          = 16;
    localparam int unsigned CLK_FREQ           = 25_000_000;
    localparam int unsigned PWM_FREQ           = 1_250;
    localparam int unsigned PWM_DEFAULT_PERIOD = CLK_FREQ / PWM_FREQ;

    // A zero period would never wrap; it is treated as a one-cycle period.
    function automatic int unsigned clamp_period(input int unsigned period);
        return (period == 32'd0) ? 32'd1 : period;
    endfunction

endpackage

// File: rtl/pwm_multichannel_gen_if.sv
// Configuration port of the PWM generator: period and packed per-channel duty, valid/ready.
interface pwm_multichannel_gen_if
    import pwm_pkg::*;
#(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned WIDTH    = PWM_WIDTH
) ();

    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [WIDTH-1:0]          cfg_period;
    logic [CHANNELS*WIDTH-1:0] cfg_duty;

    modport master (
        output cfg_valid,
        output cfg_period,
        output cfg_duty,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_period,
        input  cfg_duty,
        output cfg_ready
    );

endinterface

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: holds the active duty and registers the compare against the next count.
module pwm_channel_cmp
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_duty,
    input  logic [WIDTH-1:0] cnt_next,
    output logic             pwm_out
);

    logic [WIDTH-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;

    // Compare uses next-state count and duty so the registered output lines up with cnt.
    always_comb begin
        duty_d = load ? load_duty : duty_q;
        pwm_d  = enable & (cnt_next < duty_d);
    end

    // Active duty and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_multichannel_gen.sv
// Double-buffered multi-channel PWM: shared period counter, pending config buffer applied
// only at a period boundary (or immediately while disabled), one registered output per channel.
module pwm_multichannel_gen
    import pwm_pkg::*;
#(
    parameter int unsigned CHANNELS       = 8,
    parameter int unsigned WIDTH          = PWM_WIDTH,
    parameter int unsigned DEFAULT_PERIOD = PWM_DEFAULT_PERIOD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    pwm_multichannel_gen_if.slave cfg,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic                  period_tick
);

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]          act_period_q, act_period_d;
    logic [WIDTH-1:0]          pend_period_q, pend_period_d;
    logic [CHANNELS*WIDTH-1:0] pend_duty_q, pend_duty_d;
    logic                      pend_full_q, pend_full_d;
    logic                      tick_q, tick_d;
    logic                      accept, wrap, apply;

    assign cfg.cfg_ready = ~pend_full_q;
    assign accept        = cfg.cfg_valid & ~pend_full_q;
    // >= rather than == so a count can never run past the period.
    assign wrap          = (cnt_q >= act_period_q - One);
    // accept and apply are exclusive, so a set taken at a wrap waits for the next one.
    assign apply         = pend_full_q & (~enable | wrap);

    // Pending buffer: filled by the handshake, emptied when applied.
    always_comb begin
        pend_full_d   = pend_full_q;
        pend_period_d = pend_period_q;
        pend_duty_d   = pend_duty_q;
        if (accept) begin
            pend_full_d   = 1'b1;
            pend_period_d = WIDTH'(clamp_period(32'(cfg.cfg_period)));
            pend_duty_d   = cfg.cfg_duty;
        end else if (apply) begin
            pend_full_d = 1'b0;
        end
    end

    // Period counter; while disabled it parks on the last count so re-enable wraps at once.
    always_comb begin
        act_period_d = apply ? pend_period_q : act_period_q;
        if (!enable) begin
            cnt_d = act_period_d - One;
        end else if (wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + One;
        end
        tick_d = enable & (cnt_d == act_period_d - One);
    end

    // Counter, active period, pending buffer and tick registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= WIDTH'(DEFAULT_PERIOD - 1);
            act_period_q  <= WIDTH'(DEFAULT_PERIOD);
            pend_period_q <= '0;
            pend_duty_q   <= '0;
            pend_full_q   <= 1'b0;
            tick_q        <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            act_period_q  <= act_period_d;
            pend_period_q <= pend_period_d;
            pend_duty_q   <= pend_duty_d;
            pend_full_q   <= pend_full_d;
            tick_q        <= tick_d;
        end
    end

    assign period_tick = tick_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel_cmp #(
            .WIDTH(WIDTH)
        ) u_cmp (
            .clk      (clk),
            .rst_n    (rst_n),
            .enable   (enable),
            .load     (apply),
            .load_duty(pend_duty_q[i*WIDTH +: WIDTH]),
            .cnt_next (cnt_d),
            .pwm_out  (pwm_out[i])
        );
    end

endmodule
